// File: rtl/fifo_packetizer_if.sv
// Handshake bundle for fifo_packetizer: FWFT FIFO read port plus the outbound framed stream.
// master = packetizer side, slave = FIFO/downstream environment side.
interface fifo_packetizer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic [ADDR_WIDTH:0]   fifo_count;

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_first;
    logic                  m_last;

    modport master (
        output fifo_rd_en, m_valid, m_data, m_first, m_last,
        input  fifo_rd_data, fifo_empty, fifo_count, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_valid, m_data, m_first, m_last,
        output fifo_rd_data, fifo_empty, fifo_count, m_ready
    );
endinterface

// File: rtl/fifo_packetizer.sv
// Drains a FWFT FIFO into framed packets: length header, 1..PKT_LEN payload beats,
// two's-complement checksum trailer. Short packets are flushed after an idle timeout.
module fifo_packetizer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int unsigned PKT_LEN    = 8,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic              clk,
    input  logic              rst,
    fifo_packetizer_if.master bus,
    output logic [15:0]       pkt_count,
    output logic              busy
);
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    // Clamp so the full-packet threshold is always reachable by the FIFO occupancy.
    localparam int unsigned PktLenEff = (PKT_LEN > FIFO_DEPTH) ? FIFO_DEPTH : PKT_LEN;
    localparam logic [CW-1:0] PktLenC  = CW'(PktLenEff);
    localparam logic [TW-1:0] TimeoutC = TW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StTrailer} state_e;

    state_e                state_q;
    logic [TW-1:0]         timer_q;
    logic [CW-1:0]         len_q;
    logic [CW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] csum_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [15:0]           pkt_count_q;
    logic                  valid_q;
    logic                  first_q;
    logic                  last_q;
    logic                  busy_q;

    logic                  in_payload;
    logic                  xfer;
    logic                  start_full;
    logic                  start_tmo;
    logic [DATA_WIDTH-1:0] csum_nxt;

    assign in_payload = (state_q == StPayload);

    // Payload validity follows the FIFO head; header/trailer validity is registered.
    assign bus.m_valid    = !rst && (in_payload ? !bus.fifo_empty : valid_q);
    assign bus.m_data     = in_payload ? bus.fifo_rd_data : hold_q;
    assign bus.m_first    = first_q;
    assign bus.m_last     = last_q;
    assign xfer           = bus.m_valid && bus.m_ready;
    assign bus.fifo_rd_en = xfer && in_payload;

    assign start_full = (bus.fifo_count >= PktLenC);
    assign start_tmo  = (timer_q == TimeoutC);
    assign csum_nxt   = csum_q + bus.fifo_rd_data;

    assign pkt_count = pkt_count_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            hold_q      <= '0;
            pkt_count_q <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_full || start_tmo) begin
                        len_q   <= start_full ? PktLenC : bus.fifo_count;
                        hold_q  <= start_full ? DATA_WIDTH'(PktLenC)
                                              : DATA_WIDTH'(bus.fifo_count);
                        timer_q <= '0;
                        valid_q <= 1'b1;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StHeader;
                    end else if (bus.fifo_count != '0) begin
                        // Leaves IDLE at TimeoutC, so this never runs past it.
                        timer_q <= timer_q + TW'(1);
                    end else begin
                        timer_q <= '0;
                    end
                end
                StHeader: begin
                    if (xfer) begin
                        csum_q  <= hold_q;
                        idx_q   <= '0;
                        first_q <= 1'b0;
                        state_q <= StPayload;
                    end
                end
                StPayload: begin
                    if (xfer) begin
                        csum_q <= csum_nxt;
                        idx_q  <= idx_q + CW'(1);
                        if (idx_q == len_q - CW'(1)) begin
                            hold_q  <= ~csum_nxt + DATA_WIDTH'(1);
                            last_q  <= 1'b1;
                            state_q <= StTrailer;
                        end
                    end
                end
                StTrailer: begin
                    if (xfer) begin
                        pkt_count_q <= pkt_count_q + 16'd1;
                        valid_q     <= 1'b0;
                        last_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_packetizer.sv
// Bench for fifo_packetizer: queue-based FWFT FIFO model, packet-level stream checker,
// and directed scenarios with hand-computed lengths, checksums and latencies.
module tb_fifo_packetizer;
    localparam int unsigned DW      = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned PKT_LEN = 8;
    localparam int unsigned TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt_count;
    logic        busy;

    fifo_packetizer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    fifo_packetizer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .PKT_LEN   (PKT_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc),
        .pkt_count(pkt_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pops   = 0;
    int first_push_cyc = 0;
    bit rand_ready = 1'b0;

    logic       push_en   = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic [7:0] fifo_q[$];
    logic [7:0] ref_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Upstream FWFT FIFO; every accepted word is also the reference output order.
    always @(posedge clk) begin
        cyc++;
        if (ifc.fifo_rd_en === 1'b1 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (push_en && fifo_q.size() < DEPTH) begin
            fifo_q.push_back(push_data);
            ref_q.push_back(push_data);
        end
        ifc.fifo_count   <= CW'(fifo_q.size());
        ifc.fifo_empty   <= (fifo_q.size() == 0);
        ifc.fifo_rd_data <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Stream model: 0 expect header, 1 expect payload, 2 expect trailer.
    int         exp_pos    = 0;
    int         cur_len    = 0;
    int         cur_idx    = 0;
    logic [7:0] cur_sum    = 8'h00;
    int         model_pkts = 0;
    int         hdr_cyc    = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_first = 1'b0;
    logic       prev_last  = 1'b0;
    int len_q[$];
    int trl_q[$];
    int hcyc_q[$];
    int tcyc_q[$];

    always @(negedge clk) begin
        bit         xfer;
        logic [7:0] exp_w;
        if (rst) begin
            chk("rd_en_during_rst", int'(ifc.fifo_rd_en), 0);
            exp_pos    = 0;
            cur_idx    = 0;
            model_pkts = 0;
            prev_stall = 1'b0;
        end else begin
            xfer = ifc.m_valid && ifc.m_ready;
            if (prev_stall) begin
                chk("stall_valid", int'(ifc.m_valid), 1);
                chk("stall_data",  int'(ifc.m_data),  int'(prev_data));
                chk("stall_first", int'(ifc.m_first), int'(prev_first));
                chk("stall_last",  int'(ifc.m_last),  int'(prev_last));
            end
            chk("busy_vs_valid", int'(busy), int'(ifc.m_valid));
            chk("pkt_count", int'(pkt_count), model_pkts & 32'hFFFF);
            chk("rd_en", int'(ifc.fifo_rd_en), int'(xfer && exp_pos == 1));
            if (ifc.fifo_rd_en) chk("rd_en_when_empty", int'(ifc.fifo_empty), 0);
            if (xfer) begin
                case (exp_pos)
                    0: begin
                        chk("hdr_first", int'(ifc.m_first), 1);
                        chk("hdr_last", int'(ifc.m_last), 0);
                        cur_len = int'(ifc.m_data);
                        chk("hdr_len_range", int'(cur_len >= 1 && cur_len <= PKT_LEN), 1);
                        cur_sum = ifc.m_data;
                        cur_idx = 0;
                        hdr_cyc = cyc;
                        exp_pos = (cur_len == 0) ? 2 : 1;
                    end
                    1: begin
                        chk("pay_first", int'(ifc.m_first), 0);
                        chk("pay_last", int'(ifc.m_last), 0);
                        if (ref_q.size() == 0) begin
                            chk("pay_unexpected_word", 1, 0);
                        end else begin
                            exp_w = ref_q.pop_front();
                            chk("pay_data", int'(ifc.m_data), int'(exp_w));
                        end
                        cur_sum = cur_sum + ifc.m_data;
                        cur_idx++;
                        if (cur_idx == cur_len) exp_pos = 2;
                    end
                    default: begin
                        chk("trl_first", int'(ifc.m_first), 0);
                        chk("trl_last", int'(ifc.m_last), 1);
                        chk("trl_sum_zero", int'(8'(cur_sum + ifc.m_data)), 0);
                        len_q.push_back(cur_len);
                        trl_q.push_back(int'(ifc.m_data));
                        hcyc_q.push_back(hdr_cyc);
                        tcyc_q.push_back(cyc);
                        model_pkts++;
                        exp_pos = 0;
                    end
                endcase
            end
            prev_stall = ifc.m_valid && !ifc.m_ready;
            prev_data  = ifc.m_data;
            prev_first = ifc.m_first;
            prev_last  = ifc.m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ifc.m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_seq(input logic [7:0] base, input logic [7:0] step, input int n);
        first_push_cyc = cyc + 1;
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = base + 8'(i) * step;
            tick();
        end
        push_en = 1'b0;
    endtask

    task automatic wait_pkts(input int n, input int budget, input string name);
        int k = 0;
        while (len_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_timeout"}, int'(len_q.size() >= n), 1);
    endtask

    task automatic pop_rec(output int len, output int trl, output int hc, output int tc);
        len = -1; trl = -1; hc = 0; tc = 0;
        if (len_q.size() > 0) begin
            len = len_q.pop_front();
            trl = trl_q.pop_front();
            hc  = hcyc_q.pop_front();
            tc  = tcyc_q.pop_front();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, trl, hc, tc, p0, k;
        ifc.m_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("c1_m_valid", int'(ifc.m_valid), 0);
        chk("c1_rd_en", int'(ifc.fifo_rd_en), 0);
        chk("c1_pkt_count", int'(pkt_count), 0);
        chk("c1_busy", int'(busy), 0);

        // Full packet: 08, 01..08, D4 back-to-back.
        push_seq(8'h01, 8'h01, 8);
        wait_pkts(1, 100, "c2");
        pop_rec(len, trl, hc, tc);
        chk("c2_len", len, 8);
        chk("c2_trailer", trl, 'hD4);
        chk("c2_span", tc - hc, 9);
        chk("c2_latency", hc - first_push_cyc, 8);
        chk("c2_pkt_count", int'(pkt_count), 1);
        chk("c2_busy_after", int'(busy), 0);

        // Short packet after the idle timeout: 03, AA, BB, CC, CC.
        push_seq(8'hAA, 8'h11, 3);
        wait_pkts(1, 200, "c3");
        pop_rec(len, trl, hc, tc);
        chk("c3_len", len, 3);
        chk("c3_trailer", trl, 'hCC);
        chk("c3_timeout_latency", hc - first_push_cyc, 33);
        chk("c3_span", tc - hc, 4);

        // Same stream as case 2 under random backpressure.
        p0 = pops;
        rand_ready = 1'b1;
        push_seq(8'h01, 8'h01, 8);
        wait_pkts(1, 400, "c4");
        rand_ready = 1'b0;
        ifc.m_ready = 1'b1;
        pop_rec(len, trl, hc, tc);
        chk("c4_len", len, 8);
        chk("c4_trailer", trl, 'hD4);
        chk("c4_pops", pops - p0, 8);

        // 12 words: an 8-word packet at once, then a 4-word flush.
        push_seq(8'h20, 8'h01, 12);
        wait_pkts(2, 300, "c5a");
        pop_rec(len, trl, hc, tc);
        chk("c5a_len0", len, 8);
        pop_rec(len, trl, hc, tc);
        chk("c5a_len1", len, 4);

        // Writes landing while the first packet's payload is streaming.
        push_seq(8'h40, 8'h01, 8);
        k = 0;
        while (exp_pos == 0 && k < 50) begin
            tick();
            k++;
        end
        chk("c5b_header_seen", int'(exp_pos != 0), 1);
        push_seq(8'h50, 8'h01, 6);
        wait_pkts(2, 300, "c5b");
        pop_rec(len, trl, hc, tc);
        chk("c5b_len0", len, 8);
        pop_rec(len, trl, hc, tc);
        chk("c5b_len1", len, 6);
        chk("c5b_ref_drained", ref_q.size(), 0);

        // Reset after 3 payload beats: the other 5 words flush as 05,04..08,DD.
        push_seq(8'h01, 8'h01, 8);
        k = 0;
        while (!(exp_pos == 1 && cur_idx >= 3) && k < 60) begin
            tick();
            k++;
        end
        chk("c6_reached_beat3", int'(cur_idx), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("c6_valid_after_rst", int'(ifc.m_valid), 0);
        chk("c6_pkt_count_rst", int'(pkt_count), 0);
        chk("c6_busy_rst", int'(busy), 0);
        chk("c6_fifo_kept", int'(ifc.fifo_count), 5);
        wait_pkts(1, 200, "c6");
        pop_rec(len, trl, hc, tc);
        chk("c6_len", len, 5);
        chk("c6_trailer", trl, 'hDD);
        chk("c6_pkt_count", int'(pkt_count), 1);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
